mem_cntrl: RTL and testbench

//  Line-transfer controller directly downstream of the cpu loopback engine.

---
 rtl/mem_cntrl_if.sv | 24 ++
 rtl/mem_cntrl.sv | 126 ++++++++++++
 tb/tb_mem_cntrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cntrl_if.sv
// Memory-side line port of the line-transfer controller.
// The controller uses the master view; a memory model or fabric uses the slave view.
interface mem_cntrl_if #(
   parameter int ADDR_W = 64,
   parameter int LINE_W = 512
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_req;
   logic              mem_wr_req;
   logic [LINE_W-1:0] mem_wr_data;
   logic              mem_rdy;
   logic              mem_rd_valid;
   logic [LINE_W-1:0] mem_rd_data;

   modport master (
      output mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
      input  mem_rdy, mem_rd_valid, mem_rd_data
   );

   modport slave (
      input  mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
      output mem_rdy, mem_rd_valid, mem_rd_data
   );
endinterface

// File: rtl/mem_cntrl.sv
// Line-transfer controller: turns word-serial cpu reads/writes on the common
// data bus into single full-line transactions on the memory port.
module mem_cntrl #(
   parameter int WORDS  = 16,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 64,
   parameter int LINE_W = WORDS * WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] io_address,
   input  logic [WORD_W-1:0] common_data_bus_in,
   output logic [WORD_W-1:0] common_data_bus_out,
   output logic              rd_valid,
   output logic              tx_done,
   mem_cntrl_if.master       mem
);

   localparam int CNT_W = $clog2(WORDS);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
   localparam logic [1:0] OP_RD = 2'b01;
   localparam logic [1:0] OP_WR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_STREAM,
      WR_COLLECT,
      WR_REQ
   } state_t;

   state_t                         state, next_state;
   logic [CNT_W-1:0]               cnt;
   logic [ADDR_W-1:0]              addr_q;
   logic [WORDS-1:0][WORD_W-1:0]   line_q;
   logic                           last_word;

   assign last_word       = (cnt == CNT_W'(WORDS - 1));
   assign mem.mem_addr    = addr_q;
   assign mem.mem_wr_data = line_q;

   // The counter wraps back to 0 after every full line, so the write path
   // never needs its own clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
         line_q <= '0;
      end else begin
         state <= next_state;
         unique case (state)
            IDLE: begin
               if (op == OP_RD || op == OP_WR)
                  addr_q <= io_address & ~OFF_MASK;
            end
            RD_WAIT: begin
               if (mem.mem_rd_valid) begin
                  line_q <= mem.mem_rd_data;
                  cnt    <= '0;
               end
            end
            RD_STREAM: begin
               cnt <= cnt + 1'b1;
            end
            WR_COLLECT: begin
               line_q[cnt] <= common_data_bus_in;
               cnt         <= cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      next_state          = state;
      common_data_bus_out = '0;
      rd_valid            = 1'b0;
      tx_done             = 1'b0;
      mem.mem_rd_req      = 1'b0;
      mem.mem_wr_req      = 1'b0;
      unique case (state)
         IDLE: begin
            if (op == OP_RD)
               next_state = RD_REQ;
            else if (op == OP_WR)
               next_state = WR_COLLECT;
         end
         RD_REQ: begin
            mem.mem_rd_req = 1'b1;
            if (mem.mem_rdy)
               next_state = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem.mem_rd_valid)
               next_state = RD_STREAM;
         end
         RD_STREAM: begin
            rd_valid            = 1'b1;
            common_data_bus_out = line_q[cnt];
            if (last_word) begin
               tx_done    = 1'b1;
               next_state = IDLE;
            end
         end
         WR_COLLECT: begin
            if (last_word) begin
               tx_done    = 1'b1;
               next_state = WR_REQ;
            end
         end
         WR_REQ: begin
            mem.mem_wr_req = 1'b1;
            if (mem.mem_rdy)
               next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_cntrl.sv
// Self-checking bench for mem_cntrl: table vectors, directed corner cases and
// randomized read/write transactions against a line-level reference model.
module tb_mem_cntrl;

   localparam int WORDS  = 16;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 64;
   localparam int LINE_W = 512;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        op;
   logic [ADDR_W-1:0] io_address;
   logic [WORD_W-1:0] bus_in;
   logic [WORD_W-1:0] bus_out;
   logic              rd_valid;
   logic              tx_done;

   int checks   = 0;
   int failures = 0;
   logic [WORD_W-1:0] cpu_rx[$];

   mem_cntrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mif ();

   mem_cntrl #(.WORDS(WORDS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .op                  (op),
      .io_address          (io_address),
      .common_data_bus_in  (bus_in),
      .common_data_bus_out (bus_out),
      .rd_valid            (rd_valid),
      .tx_done             (tx_done),
      .mem                 (mif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]        vop;
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] base;
      int                rdy_dly;
      int                vld_dly;
      logic [ADDR_W-1:0] exp_addr;
   } vec_t;

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] o, input logic [ADDR_W-1:0] a,
                                input logic [WORD_W-1:0] d);
      op         = o;
      io_address = a;
      bus_in     = d;
   endtask

   // Reference model: a line starts at the byte address rounded down to 64.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
      return a - (a % 64);
   endfunction

   function automatic logic [LINE_W-1:0] make_line(input logic [WORD_W-1:0] base);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < WORDS; i++) l[i*WORD_W +: WORD_W] = base + WORD_W'(i);
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < WORDS; i++) l[i*WORD_W +: WORD_W] = $urandom;
      return l;
   endfunction

   function automatic logic [1:0] rand_nop();
      return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
   endfunction

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_bus_out"},  bus_out, 0);
      checkOutput({tag, "_rd_valid"}, rd_valid, 0);
      checkOutput({tag, "_tx_done"},  tx_done, 0);
      checkOutput({tag, "_rd_req"},   mif.mem_rd_req, 0);
      checkOutput({tag, "_wr_req"},   mif.mem_wr_req, 0);
      checkOutput({tag, "_addr"},     mif.mem_addr, 0);
      checkOutput({tag, "_wr_data"},  mif.mem_wr_data, 0);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle.
   // abort_at >= 0 pulls rst_n low while that word is on the bus.
   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] exp_addr,
                          input logic [LINE_W-1:0] line, input int rdy_dly,
                          input int vld_dly, input int abort_at);
      applyStimulus(2'b01, a, $urandom);
      @(negedge clk);
      applyStimulus(rand_nop(), {$urandom, $urandom}, $urandom);
      #1;
      checkOutput("rd_req_latency", mif.mem_rd_req, 1);
      checkOutput("rd_addr", mif.mem_addr, exp_addr);
      for (int k = 0; k < rdy_dly; k++) begin
         @(negedge clk);
         #1 checkOutput("rd_req_held", mif.mem_rd_req, 1);
      end
      mif.mem_rdy = 1'b1;
      @(negedge clk);
      mif.mem_rdy = 1'b0;
      #1;
      checkOutput("rd_req_drop", mif.mem_rd_req, 0);
      checkOutput("rd_wait_valid", rd_valid, 0);
      for (int k = 0; k < vld_dly; k++) begin
         @(negedge clk);
         #1 checkOutput("rd_wait_valid", rd_valid, 0);
      end
      mif.mem_rd_valid = 1'b1;
      mif.mem_rd_data  = line;
      @(negedge clk);
      mif.mem_rd_valid = 1'b0;
      mif.mem_rd_data  = rand_line();
      for (int i = 0; i < WORDS; i++) begin
         #1;
         checkOutput("rd_stream_valid", rd_valid, 1);
         checkOutput("rd_stream_word", bus_out, line[i*WORD_W +: WORD_W]);
         checkOutput("rd_stream_done", tx_done, (i == WORDS - 1) ? 1 : 0);
         cpu_rx.push_back(bus_out);
         if (i == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_all_zero("rst_async");
            @(negedge clk);
            #1 check_all_zero("rst_held");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
      #1;
      checkOutput("rd_end_valid", rd_valid, 0);
      checkOutput("rd_end_done", tx_done, 0);
      checkOutput("rd_end_bus", bus_out, 0);
   endtask

   // The cpu presents word 0 on the skip cycle and again on the first
   // collect cycle. hold_read keeps op=01 asserted throughout.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] exp_addr,
                           input logic [LINE_W-1:0] drive, input logic [LINE_W-1:0] exp_line,
                           input int rdy_dly, input bit hold_read);
      applyStimulus(2'b11, a, drive[WORD_W-1:0]);
      @(negedge clk);
      for (int i = 0; i < WORDS; i++) begin
         applyStimulus(hold_read ? 2'b01 : rand_nop(), {$urandom, $urandom},
                       drive[i*WORD_W +: WORD_W]);
         #1;
         checkOutput("wr_collect_done", tx_done, (i == WORDS - 1) ? 1 : 0);
         checkOutput("wr_collect_rdv", rd_valid, 0);
         checkOutput("wr_collect_req", mif.mem_wr_req, 0);
         @(negedge clk);
      end
      #1;
      checkOutput("wr_req", mif.mem_wr_req, 1);
      checkOutput("wr_addr", mif.mem_addr, exp_addr);
      checkOutput("wr_data", mif.mem_wr_data, exp_line);
      checkOutput("wr_req_done", tx_done, 0);
      for (int k = 0; k < rdy_dly; k++) begin
         @(negedge clk);
         #1;
         checkOutput("wr_req_held", mif.mem_wr_req, 1);
         checkOutput("wr_no_rd_req", mif.mem_rd_req, 0);
         checkOutput("wr_data_stable", mif.mem_wr_data, exp_line);
      end
      mif.mem_rdy = 1'b1;
      @(negedge clk);
      mif.mem_rdy = 1'b0;
      #1;
      checkOutput("wr_req_drop", mif.mem_wr_req, 0);
      checkOutput("wr_idle_rd_req", mif.mem_rd_req, 0);
   endtask

   initial begin
      vec_t vecs[4];
      logic [LINE_W-1:0] line, echo;
      logic [ADDR_W-1:0] a;

      vecs[0] = '{2'b01, 64'h47, 32'hA000_0000, 2, 1, 64'h40};
      vecs[1] = '{2'b11, 64'h400, 32'h0000_5000, 0, 0, 64'h400};
      vecs[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234_0000, 0, 3,
                  64'hFFFF_FFFF_FFFF_FFC0};
      vecs[3] = '{2'b11, 64'h3F, 32'hDEAD_0000, 3, 0, 64'h0};

      rst_n            = 1'b1;
      mif.mem_rdy      = 1'b0;
      mif.mem_rd_valid = 1'b0;
      mif.mem_rd_data  = '0;
      applyStimulus(2'b00, '0, '0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] table vectors");
      for (int v = 0; v < 4; v++) begin
         line = make_line(vecs[v].base);
         if (vecs[v].vop == 2'b01)
            do_read(vecs[v].addr, vecs[v].exp_addr, line, vecs[v].rdy_dly, vecs[v].vld_dly, -1);
         else
            do_write(vecs[v].addr, vecs[v].exp_addr, line, line, vecs[v].rdy_dly, 1'b0);
      end

      $display("[TB] loopback read then write");
      cpu_rx.delete();
      line = rand_line();
      a    = {$urandom, $urandom};
      do_read(a, line_addr(a), line, 1, 2, -1);
      for (int i = 0; i < WORDS; i++) echo[i*WORD_W +: WORD_W] = cpu_rx[i];
      do_write(a, line_addr(a), echo, line, 1, 1'b0);

      $display("[TB] write back-pressure with read pending");
      line = rand_line();
      do_write(64'h1000, 64'h1000, line, line, 10, 1'b1);
      do_read(64'h2044, 64'h2040, make_line(32'h7700_0000), 0, 1, -1);

      $display("[TB] reset during read stream");
      do_read(64'h80, 64'h80, make_line(32'hBEEF_0000), 1, 1, 5);
      do_read(64'hC5, 64'hC0, make_line(32'hC0DE_0000), 0, 0, -1);

      $display("[TB] nop hold");
      for (int k = 0; k < 20; k++) begin
         applyStimulus(rand_nop(), {$urandom, $urandom}, $urandom);
         mif.mem_rdy      = 1'($urandom_range(0, 1));
         mif.mem_rd_valid = 1'($urandom_range(0, 1));
         #1;
         checkOutput("nop_rd_req", mif.mem_rd_req, 0);
         checkOutput("nop_wr_req", mif.mem_wr_req, 0);
         checkOutput("nop_rd_valid", rd_valid, 0);
         checkOutput("nop_tx_done", tx_done, 0);
         @(negedge clk);
      end
      mif.mem_rdy      = 1'b0;
      mif.mem_rd_valid = 1'b0;
      applyStimulus(2'b00, '0, '0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 12; t++) begin
         line = rand_line();
         a    = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1)
            do_read(a, line_addr(a), line, $urandom_range(0, 4), $urandom_range(0, 4), -1);
         else
            do_write(a, line_addr(a), line, line, $urandom_range(0, 4), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
